// File: rtl/rs_pkg.sv
// rs_pkg: shared constants, reservation-station entry type and the wakeup helper
package rs_pkg;
  localparam int DEPTH   = 4;
  localparam int NUM_OPS = 3;
  localparam int PRN_W   = 7;
  localparam int ID_W    = 6;
  localparam int NUM_WB  = 2;
  localparam int XLEN    = 64;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  typedef struct packed {
    logic                            valid;
    logic [31:0]                     inst;
    logic [ID_W-1:0]                 inst_id;
    logic [NUM_OPS-1:0][PRN_W-1:0]   src_prn;
    logic [NUM_OPS-1:0]              src_rdy;
    logic [NUM_OPS-1:0][XLEN-1:0]    src_val;
    logic [NUM_OPS-1:0][PRN_W-1:0]   dst_prn;
    logic [NUM_OPS-1:0]              dst_valid;
  } rs_entry_t;
  // Ports are scanned upward and a captured source becomes ready at once, so the lowest matching port wins.
  function automatic rs_entry_t wakeup(input rs_entry_t e, input logic [NUM_WB-1:0] v,
                                       input logic [NUM_WB-1:0][PRN_W-1:0] p,
                                       input logic [NUM_WB-1:0][XLEN-1:0] d);
    rs_entry_t r;
    r = e;
    for (int k = 0; k < NUM_OPS; k++)
      for (int w = 0; w < NUM_WB; w++)
        if (!r.src_rdy[k] && v[w] && p[w] == r.src_prn[k]) begin
          r.src_val[k] = d[w];
          r.src_rdy[k] = 1'b1;
        end
    return r;
  endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: combinational oldest-ready picker over an age matrix
// Ports: i_age[j][i]=1 means entry j is older than entry i; i_rdy ready vector;
//        o_grant one-hot oldest ready entry; o_found any entry ready.
module rs_age_select
  import rs_pkg::*;
(
  input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
  input  logic [DEPTH-1:0]            i_rdy,
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_found
);
  always_comb begin
    o_grant = i_rdy;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && i_rdy[j] && i_age[j][i]) o_grant[i] = 1'b0;
  end
  assign o_found = |i_rdy;
endmodule

// File: rtl/fu_reservation_station.sv
// fu_reservation_station: per-FU station buffering dispatched instructions and issuing the oldest ready one
// Ports: clk/rst (async active-high); flush drops everything; disp_* dispatch handshake and payload;
//        wb_* writeback broadcasts; fu_ready FU accept; inst_valid/inst/inst_id/op/out_prn/out_prn_valid
//        registered issue outputs; occupancy valid entry count.
// Option: RS_DISPATCH_BYPASS_EN lets a ready dispatch into an idle station issue on its dispatch edge.
module fu_reservation_station
  import rs_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [31:0]                disp_inst,
  input  logic [ID_W-1:0]            disp_inst_id,
  input  logic [NUM_OPS*PRN_W-1:0]   disp_src_prn,
  input  logic [NUM_OPS-1:0]         disp_src_rdy,
  input  logic [NUM_OPS*XLEN-1:0]    disp_src_val,
  input  logic [NUM_OPS*PRN_W-1:0]   disp_dst_prn,
  input  logic [NUM_OPS-1:0]         disp_dst_valid,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PRN_W-1:0]    wb_prn,
  input  logic [NUM_WB*XLEN-1:0]     wb_data,
  input  logic                       fu_ready,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [ID_W-1:0]            inst_id,
  output logic [NUM_OPS*XLEN-1:0]    op,
  output logic [NUM_OPS*PRN_W-1:0]   out_prn,
  output logic [NUM_OPS-1:0]         out_prn_valid,
  output logic [CNT_W-1:0]           occupancy
);
  rs_entry_t [DEPTH-1:0]          r_ent, w_nxt;
  logic [DEPTH-1:0][DEPTH-1:0]    r_age, w_age_nxt;
  logic [CNT_W-1:0]               r_occ;
  logic                           r_inst_valid;
  logic [31:0]                    r_inst;
  logic [ID_W-1:0]                r_inst_id;
  logic [NUM_OPS*XLEN-1:0]        r_op;
  logic [NUM_OPS*PRN_W-1:0]       r_out_prn;
  logic [NUM_OPS-1:0]             r_out_prn_valid;
  rs_entry_t                      w_raw, w_disp;
  logic [DEPTH-1:0]               w_rdy, w_grant;
  logic                           w_found, w_issue, w_byp, w_do_disp;
  logic [IDX_W-1:0]               w_slot;
  logic [31:0]                    w_sel_inst;
  logic [ID_W-1:0]                w_sel_id;
  logic [NUM_OPS*XLEN-1:0]        w_sel_op;
  logic [NUM_OPS*PRN_W-1:0]       w_sel_prn;
  logic [NUM_OPS-1:0]             w_sel_pv;
  rs_age_select u_sel (.i_age(r_age), .i_rdy(w_rdy), .o_grant(w_grant), .o_found(w_found));
  assign disp_ready = r_occ != CNT_W'(DEPTH);
  assign w_issue    = w_found & fu_ready;
`ifdef RS_DISPATCH_BYPASS_EN
  assign w_byp      = !w_found & disp_valid & disp_ready & fu_ready & (&w_disp.src_rdy);
`else
  assign w_byp      = 1'b0;
`endif
  assign w_do_disp  = disp_valid & disp_ready & !w_byp;
  always_comb begin
    w_raw.valid     = 1'b1;
    w_raw.inst      = disp_inst;
    w_raw.inst_id   = disp_inst_id;
    w_raw.src_prn   = disp_src_prn;
    w_raw.src_rdy   = disp_src_rdy;
    w_raw.src_val   = disp_src_val;
    w_raw.dst_prn   = disp_dst_prn;
    w_raw.dst_valid = disp_dst_valid;
    w_disp          = wakeup(w_raw, wb_valid, wb_prn, wb_data);
  end
  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < DEPTH; i++) w_rdy[i] = r_ent[i].valid & (&r_ent[i].src_rdy);
  end
  // Selection uses registered readiness; wakeups only become visible the cycle after they land.
  always_comb begin
    w_slot     = '0;
    w_sel_inst = '0;
    w_sel_id   = '0;
    w_sel_op   = '0;
    w_sel_prn  = '0;
    w_sel_pv   = '0;
    w_nxt      = r_ent;
    w_age_nxt  = r_age;
    for (int i = DEPTH - 1; i >= 0; i--) if (!r_ent[i].valid) w_slot = IDX_W'(i);
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = wakeup(r_ent[i], wb_valid, wb_prn, wb_data);
      if (w_grant[i]) begin
        w_sel_inst = r_ent[i].inst;
        w_sel_id   = r_ent[i].inst_id;
        w_sel_op   = r_ent[i].src_val;
        w_sel_prn  = r_ent[i].dst_prn;
        w_sel_pv   = r_ent[i].dst_valid;
        if (w_issue) w_nxt[i].valid = 1'b0;
      end
    end
    // A new entry is younger than every other slot: clear its row, set its column.
    if (w_do_disp) begin
      w_nxt[w_slot] = w_disp;
      for (int j = 0; j < DEPTH; j++) begin
        w_age_nxt[w_slot][j] = 1'b0;
        w_age_nxt[j][w_slot] = IDX_W'(j) != w_slot;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent           <= '0;
      r_age           <= '0;
      r_occ           <= '0;
      r_inst_valid    <= 1'b0;
      r_inst          <= '0;
      r_inst_id       <= '0;
      r_op            <= '0;
      r_out_prn       <= '0;
      r_out_prn_valid <= '0;
    end else if (flush) begin
      r_ent        <= '0;
      r_occ        <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_ent        <= w_nxt;
      r_age        <= w_age_nxt;
      r_occ        <= r_occ + CNT_W'(w_do_disp) - CNT_W'(w_issue);
      r_inst_valid <= w_issue | w_byp;
      if (w_issue | w_byp) begin
        r_inst          <= w_byp ? w_disp.inst      : w_sel_inst;
        r_inst_id       <= w_byp ? w_disp.inst_id   : w_sel_id;
        r_op            <= w_byp ? w_disp.src_val   : w_sel_op;
        r_out_prn       <= w_byp ? w_disp.dst_prn   : w_sel_prn;
        r_out_prn_valid <= w_byp ? w_disp.dst_valid : w_sel_pv;
      end
    end
  end
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_id       = r_inst_id;
  assign op            = r_op;
  assign out_prn       = r_out_prn;
  assign out_prn_valid = r_out_prn_valid;
  assign occupancy     = r_occ;
endmodule
